// File: rtl/sync_ram_dp_wbe_clr.sv
// True dual-port synchronous RAM: per-byte write enables, selectable read-during-write,
// post-reset clear sweep, collision flag. Define RAM_OUTREG_EN for a second output register stage.
module sync_ram_dp_wbe_clr #(
   parameter int DWIDTH     = 32,
   parameter int AWIDTH     = 8,
   parameter int DEPTH      = 1 << AWIDTH,
   parameter int RDW_MODE   = 0,
   parameter int CLR_ON_RST = 1
) (
   input  logic                  clk,
   input  logic                  RST,
   input  logic                  en0,
   input  logic [DWIDTH/8-1:0]   wbe0,
   input  logic [AWIDTH-1:0]     addr0,
   input  logic [DWIDTH-1:0]     d0,
   output logic [DWIDTH-1:0]     q0,
   input  logic                  en1,
   input  logic [DWIDTH/8-1:0]   wbe1,
   input  logic [AWIDTH-1:0]     addr1,
   input  logic [DWIDTH-1:0]     d1,
   output logic [DWIDTH-1:0]     q1,
   output logic                  init_busy,
   output logic                  collision
);

   localparam int LANES = DWIDTH / 8;
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     ptr, ptr_nxt;
   logic              clr_we;

   logic [DWIDTH-1:0] mem [DEPTH];

   logic              acc0, acc1, hit0, hit1;
   logic [PW-1:0]     idx0, idx1;
   logic [DWIDTH-1:0] rd0, rd1;
   logic [DWIDTH-1:0] q0_r, q1_r;

   function automatic logic [DWIDTH-1:0] merge(input logic [DWIDTH-1:0] old_w,
                                               input logic [DWIDTH-1:0] new_w,
                                               input logic [LANES-1:0]  be);
      logic [DWIDTH-1:0] w;
      w = old_w;
      for (int i = 0; i < LANES; i++) begin
         if (be[i]) w[8*i +: 8] = new_w[8*i +: 8];
      end
      return w;
   endfunction

   // Sweep controller
   always_ff @(posedge clk) begin
      if (RST) begin
         state <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      clr_we    = 1'b0;
      case (state)
         CLEAR: begin
            clr_we  = !RST;
            ptr_nxt = ptr + PW'(1);
            if (ptr == PW'(DEPTH - 1)) begin
               state_nxt = IDLE;
               ptr_nxt   = '0;
            end
         end
         default: ;
      endcase
   end

   assign init_busy = (state == CLEAR);

   // Port requests count only outside reset and outside the sweep
   assign acc0 = en0 && !RST && (state == IDLE);
   assign acc1 = en1 && !RST && (state == IDLE);
   assign hit0 = acc0 && ({1'b0, addr0} < DEPTH_W);
   assign hit1 = acc1 && ({1'b0, addr1} < DEPTH_W);
   assign idx0 = addr0[PW-1:0];
   assign idx1 = addr1[PW-1:0];

   // Each port's read only ever sees its own same-cycle write
   assign rd0 = (RDW_MODE != 0) ? merge(mem[idx0], d0, wbe0) : mem[idx0];
   assign rd1 = (RDW_MODE != 0) ? merge(mem[idx1], d1, wbe1) : mem[idx1];

   // NOTE: the array has no reset term; the sweep zeroes it one word per cycle instead,
   // which keeps the storage mappable onto block RAM.
   always_ff @(posedge clk) begin
      if (clr_we) mem[ptr] <= '0;
      for (int i = 0; i < LANES; i++) begin
         if (hit0 && wbe0[i]) mem[idx0][8*i +: 8] <= d0[8*i +: 8];
      end
      // Port 1 is assigned last so it wins lanes both ports write
      for (int i = 0; i < LANES; i++) begin
         if (hit1 && wbe1[i]) mem[idx1][8*i +: 8] <= d1[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         q0_r      <= '0;
         q1_r      <= '0;
         collision <= 1'b0;
      end else begin
         if (acc0) q0_r <= hit0 ? rd0 : '0;
         if (acc1) q1_r <= hit1 ? rd1 : '0;
         collision <= hit0 && hit1 && (addr0 == addr1) && ((|wbe0) || (|wbe1));
      end
   end

`ifdef RAM_OUTREG_EN
   logic              ld0, ld1;
   logic [DWIDTH-1:0] q0_o, q1_o;

   always_ff @(posedge clk) begin
      if (RST) begin
         ld0  <= 1'b0;
         ld1  <= 1'b0;
         q0_o <= '0;
         q1_o <= '0;
      end else begin
         ld0 <= acc0;
         ld1 <= acc1;
         if (ld0) q0_o <= q0_r;
         if (ld1) q1_o <= q1_r;
      end
   end

   assign q0 = q0_o;
   assign q1 = q1_o;
`else
   assign q0 = q0_r;
   assign q1 = q1_r;
`endif

endmodule

// File: tb/tb_sync_ram_dp_wbe_clr.sv
// Bench for sync_ram_dp_wbe_clr: three instances (read-first/clear, write-first/clear,
// write-first/retain) share stimulus and are compared every cycle against an array model.
module tb_sync_ram_dp_wbe_clr;

   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 12;
   localparam int LN    = DW / 8;
   localparam logic [2:0] RDW_K = 3'b110;
   localparam logic [2:0] CLR_K = 3'b011;

   logic          clk = 1'b0;
   logic          rst;
   logic          en0, en1;
   logic [LN-1:0] wbe0, wbe1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] d0, d1;

   logic [2:0][DW-1:0] q0_k, q1_k;
   logic [2:0]         busy_k, coll_k;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      sync_ram_dp_wbe_clr #(
         .DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH),
         .RDW_MODE(int'(RDW_K[k])), .CLR_ON_RST(int'(CLR_K[k]))
      ) dut (
         .clk(clk), .RST(rst),
         .en0(en0), .wbe0(wbe0), .addr0(addr0), .d0(d0), .q0(q0_k[k]),
         .en1(en1), .wbe1(wbe1), .addr1(addr1), .d1(d1), .q1(q1_k[k]),
         .init_busy(busy_k[k]), .collision(coll_k[k])
      );
   end

   // Reference model: memory contents and what each output should show
   logic [DW-1:0] m [3][DEPTH];
   logic [DW-1:0] e_q0 [3], e_q1 [3], e_o0 [3], e_o1 [3];
   bit            e_l0 [3], e_l1 [3], e_col [3];
   int            e_busy [3];

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] apply(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                           input logic [LN-1:0] be);
      logic [DW-1:0] mask;
      for (int i = 0; i < LN; i++) mask[8*i +: 8] = {8{be[i]}};
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   task automatic model_step();
      bit ok0, ok1;
      ok0 = int'(addr0) < DEPTH;
      ok1 = int'(addr1) < DEPTH;
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            e_q0[k] = '0; e_q1[k] = '0; e_o0[k] = '0; e_o1[k] = '0;
            e_l0[k] = 0;  e_l1[k] = 0;  e_col[k] = 0;
            e_busy[k] = CLR_K[k] ? DEPTH : 0;
            if (CLR_K[k]) for (int w = 0; w < DEPTH; w++) m[k][w] = '0;
         end else begin
            if (e_l0[k]) e_o0[k] = e_q0[k];
            if (e_l1[k]) e_o1[k] = e_q1[k];
            e_l0[k] = 0; e_l1[k] = 0; e_col[k] = 0;
            if (e_busy[k] > 0) begin
               e_busy[k]--;
            end else begin
               if (en0) begin
                  e_l0[k] = 1;
                  e_q0[k] = !ok0 ? '0 : RDW_K[k] ? apply(m[k][addr0], d0, wbe0) : m[k][addr0];
               end
               if (en1) begin
                  e_l1[k] = 1;
                  e_q1[k] = !ok1 ? '0 : RDW_K[k] ? apply(m[k][addr1], d1, wbe1) : m[k][addr1];
               end
               if (en0 && ok0) m[k][addr0] = apply(m[k][addr0], d0, wbe0);
               if (en1 && ok1) m[k][addr1] = apply(m[k][addr1], d1, wbe1);
               e_col[k] = en0 && en1 && ok0 && ok1 && (addr0 == addr1) && (wbe0 != 0 || wbe1 != 0);
            end
         end
      end
   endtask

   task automatic compare_all();
      string nm;
      for (int k = 0; k < 3; k++) begin
         nm = (k == 0) ? "a" : (k == 1) ? "b" : "c";
`ifdef RAM_OUTREG_EN
         check({nm, ".q0"}, q0_k[k], e_o0[k]);
         check({nm, ".q1"}, q1_k[k], e_o1[k]);
`else
         check({nm, ".q0"}, q0_k[k], e_q0[k]);
         check({nm, ".q1"}, q1_k[k], e_q1[k]);
`endif
         check({nm, ".busy"}, DW'(busy_k[k]), DW'(e_busy[k] > 0));
         check({nm, ".coll"}, DW'(coll_k[k]), DW'(e_col[k]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle();
      en0 = 0; wbe0 = '0; addr0 = '0; d0 = '0;
      en1 = 0; wbe1 = '0; addr1 = '0; d1 = '0;
   endtask

   task automatic set0(input logic [LN-1:0] be, input int a, input logic [DW-1:0] d);
      en0 = 1; wbe0 = be; addr0 = AW'(a); d0 = d;
   endtask

   task automatic set1(input logic [LN-1:0] be, input int a, input logic [DW-1:0] d);
      en1 = 1; wbe1 = be; addr1 = AW'(a); d1 = d;
   endtask

   task automatic rand_traffic(input bit avoid2);
      en0 = ($urandom_range(3) != 0);
      wbe0 = ($urandom_range(1) == 1) ? LN'($urandom) : '0;
      addr0 = AW'($urandom);
      d0 = $urandom;
      en1 = ($urandom_range(3) != 0);
      wbe1 = ($urandom_range(1) == 1) ? LN'($urandom) : '0;
      addr1 = ($urandom_range(3) == 0) ? addr0 : AW'($urandom);
      d1 = $urandom;
      if (avoid2) begin
         if (addr0 == 2) addr0 = 3;
         if (addr1 == 2) addr1 = 3;
      end
   endtask

   // Counts cycles init_busy stays high after a reset edge, bounded
   task automatic sweep_wait(input bit fill, output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (!busy_k[0]) break;
         if (fill) begin
            idle();
            set0('1, i % DEPTH, (i == 0) ? 32'hDEADBEEF : $urandom);
         end else begin
            rand_traffic(1);
         end
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      rst = 1;
      idle();
      tick();
      tick();
      rst = 0;

      // Writes during the sweep: dropped by a/b, stored by c
      sweep_wait(1, n);
      check("busy_len", DW'(n), DW'(DEPTH));

      idle(); set0('0, 0, '0); tick();
      idle(); tick();
      check("busy_wr_drop", q0_k[0], 32'h0);
      check("c_fill", q0_k[2], 32'hDEADBEEF);

      for (int i = 0; i < DEPTH; i++) begin
         idle(); set0('0, i, '0); set1('0, DEPTH - 1 - i, '0); tick();
      end
      idle(); tick();
      check("clr_zero", q0_k[0], 32'h0);

      // Byte lanes across ports
      idle(); set0(4'b1111, 5, 32'h11223344); tick();
      idle(); set1(4'b0101, 5, 32'hAABBCCDD); tick();
      idle(); set0('0, 5, '0); tick();
      idle(); tick();
      check("lane_merge", q0_k[0], 32'h11BB33DD);

      // Read during write on the same port
      idle(); set0(4'b1111, 3, 32'h00000001); tick();
      idle(); set0(4'b0011, 3, 32'h0000FFFF); tick();
      idle(); tick();
      check("rdw_read_first", q0_k[0], 32'h00000001);
      check("rdw_write_first", q0_k[1], 32'h0000FFFF);

      // Same-address collisions
      idle(); set0(4'b1111, 7, 32'h01010101); set1(4'b0011, 7, 32'h02020202); tick();
      check("coll_ww", DW'(coll_k[0]), 32'h1);
      idle(); tick();
      check("coll_drop", DW'(coll_k[0]), 32'h0);
      idle(); set0('0, 7, '0); set1(4'b1111, 7, 32'h33333333); tick();
      check("coll_rw", DW'(coll_k[0]), 32'h1);
      idle(); tick();
      check("coll_rw_old", q0_k[0], 32'h01010202);

      // Out of range, then the top word
      idle(); set0(4'b1111, 13, 32'hCAFEF00D); tick();
      idle(); tick();
      check("oor_q", q0_k[0], 32'h0);
      idle(); set0(4'b1111, DEPTH - 1, 32'h12345678); tick();
      idle(); set1('0, DEPTH - 1, '0); tick();
      idle(); tick();
      check("top_word", q1_k[0], 32'h12345678);

      for (int i = 0; i < 300; i++) begin
         rand_traffic(0);
         tick();
      end

      // Reset mid-sweep; c must keep its contents
      idle(); set1(4'b1111, 2, 32'h5A5A5A5A); tick();
      idle(); tick();
      rand_traffic(1); rst = 1; tick(); rst = 0;
      for (int i = 0; i < 8; i++) begin
         rand_traffic(1);
         tick();
      end
      rand_traffic(1); rst = 1; tick(); rst = 0;
      sweep_wait(0, n);
      check("busy_len_restart", DW'(n), DW'(DEPTH));
      idle(); set1('0, 2, '0); tick();
      idle(); tick();
      check("c_keep", q1_k[2], 32'h5A5A5A5A);
      check("a_cleared", q1_k[0], 32'h0);

      for (int i = 0; i < 200; i++) begin
         rand_traffic(0);
         tick();
      end
      idle(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
